// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line instruction cache between the PC stage and memory.
// Latency: a hit returns the word in the same cycle. A miss takes 1 cycle to detect, then N memory cycles, then 1 hit cycle.
// Backpressure: ihit is the PC enable and stays low until the word is available. The fill waits for iwait to go low.
//
// Optional build macro: ICACHE_STATS_EN adds the hit_count and miss_count outputs.
//
// Ports:
//   CLK        clock; all state updates on the rising edge
//   RST        synchronous, active-high reset
//   imemREN    fetch request from the datapath
//   imemaddr   fetch byte address from the PC stage; bits [1:0] are ignored
//   flush      invalidates every line (driven from halt)
//   ihit       instruction valid this cycle (PC stage pcEN)
//   imemload   instruction word; zero unless ihit
//   iREN       read request to the memory controller (high for the whole FETCH state)
//   iaddr      word-aligned fill address (latched miss address)
//   iwait      memory busy; fill data is valid in a FETCH cycle with iwait=0
//   iload      fill data from memory
//   hit_count  (ICACHE_STATS_EN) cycles with ihit=1, wraps modulo 2^32
//   miss_count (ICACHE_STATS_EN) IDLE->FETCH transitions, wraps modulo 2^32

module icache_direct #(
   parameter int SETS  = 16,
   parameter int IDX_W = $clog2(SETS)
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        flush,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
`ifdef ICACHE_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
`endif
   input  logic [31:0] iload
);

   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t            state;

   // Line storage. Only the valid bits need a reset. Tag and data are
   // meaningless while the valid bit is clear.
   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tag_arr  [SETS];
   logic [31:0]       data_arr [SETS];

   // Address of the outstanding fill. It is the only source of the fill
   // index and tag, so fetch-address changes during FETCH cannot redirect the fill.
   logic [31:0]       miss_addr;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [IDX_W-1:0]  miss_idx;
   logic [TAG_W-1:0]  miss_tag;

   logic              lookup_hit;
   logic              start_fill;
   logic              fill_done;

   // Byte-offset bits are never used: fetches are whole words.
   logic              unused_bits;

   assign idx      = imemaddr[IDX_W+1:2];
   assign tag      = imemaddr[31:IDX_W+2];
   assign miss_idx = miss_addr[IDX_W+1:2];
   assign miss_tag = miss_addr[31:IDX_W+2];

   assign unused_bits = ^{imemaddr[1:0], miss_addr[1:0]};

   // Raw tag lookup. Qualifying it with state and flush happens below.
   assign lookup_hit = imemREN && valid[idx] && (tag_arr[idx] == tag);

   // A flush suppresses the hit even when the tag matches. This keeps the PC
   // from advancing on a line that is being invalidated at this edge.
   assign ihit     = (state == IDLE) && !flush && lookup_hit;
   assign imemload = ihit ? data_arr[idx] : 32'h0000_0000;

   // iREN follows the state directly. In a FETCH cycle with flush asserted it is
   // still high, and it drops once the abort has taken the FSM back to IDLE.
   assign iREN  = (state == FETCH);
   assign iaddr = miss_addr;

   // A miss starts a fill only when no flush is pending.
   assign start_fill = (state == IDLE) && imemREN && !lookup_hit && !flush;

   // Flush takes priority over a completing fill. The returned word is dropped.
   assign fill_done  = (state == FETCH) && !iwait && !flush;

   // Control state: FSM, valid bits and the miss address register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         valid     <= '0;
         miss_addr <= 32'h0000_0000;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  valid <= '0;
               end else if (start_fill) begin
                  miss_addr <= {imemaddr[31:2], 2'b00};
                  state     <= FETCH;
               end
            end
            FETCH: begin
               if (flush) begin
                  // Abort: no line is written and the whole cache is invalidated.
                  valid <= '0;
                  state <= IDLE;
               end else if (!iwait) begin
                  valid[miss_idx] <= 1'b1;
                  state           <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Tag and data arrays. The fill overwrites unconditionally, so a conflict
   // miss simply evicts whatever line was there before.
   always_ff @(posedge CLK) begin
      if (!RST && fill_done) begin
         tag_arr[miss_idx]  <= miss_tag;
         data_arr[miss_idx] <= iload;
      end
   end

`ifdef ICACHE_STATS_EN
   // Only reset clears the statistics. A flush-aborted fill still counts,
   // because the miss was counted when FETCH was entered.
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_count  <= 32'h0000_0000;
         miss_count <= 32'h0000_0000;
      end else begin
         if (ihit) begin
            hit_count <= hit_count + 32'h0000_0001;
         end
         if (start_fill) begin
            miss_count <= miss_count + 32'h0000_0001;
         end
      end
   end
`endif

endmodule
